// File: rtl/pdm_mic_ctrl.sv
// PDM mic front-end: per-window ones count, right channel only with PDM_STEREO_EN; sample valid 1 clk after window end.
// Sample held on valid until ready; a window end while stalled overwrites l/r and sets sticky overrun.
module pdm_mic_ctrl #(
  parameter int CLK_DIV = 14,
  parameter int DEC     = 128,
  parameter int WARM    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       mic_clk,
  output logic       mic_lrsel,
  input  logic       mic_data,
  output logic [7:0] l,
  output logic [7:0] r,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  input  logic       clr_overrun
);
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t     r_state;
  logic [7:0] r_phase;
  logic [7:0] r_win;
  logic [7:0] r_cnt_l;
  logic [3:0] r_wcnt;
  logic       w_last;
  logic       w_smp_l;
  logic       w_step;
  logic       w_wend;
  logic [7:0] w_cnt_l_nx;

  assign mic_lrsel  = 1'b0;
  assign w_last     = (r_phase == 8'(CLK_DIV - 1));
  assign w_smp_l    = w_last && mic_clk;
  assign w_cnt_l_nx = (w_smp_l && mic_data && (r_cnt_l != 8'hFF)) ? r_cnt_l + 8'd1 : r_cnt_l;

`ifdef PDM_STEREO_EN
  logic [7:0] r_cnt_r;
  logic       r_primed;  // the low phase before the first rising edge carries no right bit
  logic       w_smp_r;
  logic [7:0] w_cnt_r_nx;

  assign w_smp_r    = w_last && !mic_clk && r_primed;
  assign w_cnt_r_nx = (w_smp_r && mic_data && (r_cnt_r != 8'hFF)) ? r_cnt_r + 8'd1 : r_cnt_r;
  assign w_step     = w_smp_r;
`else
  assign w_step     = w_smp_l;
  assign r          = 8'd0;
`endif

  assign w_wend = w_step && (r_win == 8'(DEC - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      mic_clk <= 1'b0;
      r_phase <= 8'd0;
      r_win   <= 8'd0;
      r_cnt_l <= 8'd0;
      r_wcnt  <= 4'd0;
      l       <= 8'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
`ifdef PDM_STEREO_EN
      r_cnt_r  <= 8'd0;
      r_primed <= 1'b0;
      r        <= 8'd0;
`endif
    end else begin
      if (clr_overrun) overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) r_state <= (WARM == 0) ? RUN : WARMUP;
        end
        default: begin
          if (!enable) begin
            r_state <= IDLE;
            mic_clk <= 1'b0;
            r_phase <= 8'd0;
            r_win   <= 8'd0;
            r_cnt_l <= 8'd0;
            r_wcnt  <= 4'd0;
            valid   <= 1'b0;
`ifdef PDM_STEREO_EN
            r_cnt_r  <= 8'd0;
            r_primed <= 1'b0;
`endif
          end else begin
            r_phase <= w_last ? 8'd0 : r_phase + 8'd1;
            if (w_last) mic_clk <= ~mic_clk;
            if (valid && ready) valid <= 1'b0;
`ifdef PDM_STEREO_EN
            if (w_smp_l) r_primed <= 1'b1;
`endif
            if (w_wend) begin
              r_win   <= 8'd0;
              r_cnt_l <= 8'd0;
`ifdef PDM_STEREO_EN
              r_cnt_r <= 8'd0;
`endif
              if (r_state == WARMUP) begin
                if (r_wcnt == 4'(WARM - 1)) begin
                  r_state <= RUN;
                  r_wcnt  <= 4'd0;
                end else begin
                  r_wcnt <= r_wcnt + 4'd1;
                end
              end else begin
                l     <= w_cnt_l_nx;
`ifdef PDM_STEREO_EN
                r     <= w_cnt_r_nx;
`endif
                valid <= 1'b1;
                // set wins over a simultaneous clear
                if (valid && !ready) overrun <= 1'b1;
              end
            end else begin
              r_cnt_l <= w_cnt_l_nx;
`ifdef PDM_STEREO_EN
              r_cnt_r <= w_cnt_r_nx;
`endif
              if (w_step) r_win <= r_win + 8'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pdm_mic_ctrl.sv
`timescale 1ns/1ps
module tb_pdm_mic_ctrl;
  localparam int CLK_DIV = 2;
  localparam int DEC     = 4;
  localparam int WARM    = 1;
`ifdef PDM_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  // cycles from the enable edge to first valid: stereo ends on a right bit, mono on a left bit
  localparam int LAT = STEREO ? 35 : 33;
  localparam int PER = 2 * CLK_DIV * DEC;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       mic_clk;
  logic       mic_lrsel;
  logic       mic_data = 1'b0;
  logic [7:0] l;
  logic [7:0] r;
  logic       valid;
  logic       ready = 1'b0;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_xfer = 0;
  int last_x = 0;
  int gap    = 0;
  int pat    = 0;
  logic [15:0] q[$];

  pdm_mic_ctrl #(.CLK_DIV(CLK_DIV), .DEC(DEC), .WARM(WARM)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mic_clk(mic_clk),
    .mic_lrsel(mic_lrsel), .mic_data(mic_data), .l(l), .r(r), .valid(valid),
    .ready(ready), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected {l, r} for a whole window under each data pattern
  function automatic logic [15:0] exp_of(input int p);
    logic [7:0] full_r;
    full_r = STEREO ? 8'd4 : 8'd0;
    case (p)
      1:       exp_of = {8'd4, full_r};
      2:       exp_of = {8'd4, 8'd0};
      3:       exp_of = {8'd0, full_r};
      default: exp_of = 16'd0;
    endcase
  endfunction

  initial forever @(posedge clk) cyc++;

  // patterns: 0 all zeros, 1 all ones, 2 follows mic_clk, 3 inverse of mic_clk
  initial forever begin
    @(negedge clk);
    case (pat)
      1:       mic_data = 1'b1;
      2:       mic_data = mic_clk;
      3:       mic_data = ~mic_clk;
      default: mic_data = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (valid && ready) begin
      logic [15:0] e;
      chk("xfer_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("l", l, e[15:8]);
        chk("r", r, e[7:0]);
      end
      gap    = cyc - last_x;
      last_x = cyc;
      n_xfer++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_run(input int p, input int nexp);
    bit found;
    found = 1'b0;
    pat = p;
    for (int i = 0; i < nexp; i++) q.push_back(exp_of(p));
    enable = 1'b1;
    for (int k = 1; k <= LAT + 20 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) chk("mclk_lo_first", mic_clk, 0);
      if (k == 3) chk("mclk_hi_first", mic_clk, 1);
      if (valid) begin
        found = 1'b1;
        chk("first_valid_lat", k, LAT);
      end
    end
    if (!found) chk("valid_timeout", valid, 1);
    tick();
  endtask

  task automatic wait_xfer(input int n);
    int target;
    target = n_xfer + n;
    for (int k = 0; k < PER * n + 40 && n_xfer < target; k++) @(posedge clk);
    #1;
    chk("xfer_count", n_xfer, target);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick();
    chk("stop_valid", valid, 0);
    chk("stop_mclk", mic_clk, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ticks(3);
    chk("rst_mclk", mic_clk, 0);
    chk("rst_lrsel", mic_lrsel, 0);
    chk("rst_l", l, 0);
    chk("rst_r", r, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    ticks(2);

    // all ones, free-running consumer: one sample every PER clocks
    ready = 1'b1;
    start_run(1, 4);
    chk("run_lrsel", mic_lrsel, 0);
    wait_xfer(3);
    chk("xfer_gap", gap, PER);
    stop_run();

    start_run(2, 2);
    wait_xfer(1);
    stop_run();
    start_run(3, 2);
    wait_xfer(1);
    stop_run();
    start_run(0, 1);
    stop_run();

    // stalled consumer across three window ends
    ready = 1'b0;
    start_run(1, 1);
    ticks(14);
    chk("ovr_before", overrun, 0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_set_and_clr", overrun, 1);
    ticks(16);
    chk("ovr_held", overrun, 1);
    chk("ovr_valid", valid, 1);
    chk("ovr_l", l, exp_of(1) >> 8);
    chk("ovr_r", r, exp_of(1) & 16'hFF);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 0);
    ready = 1'b1;
    tick();
    stop_run();

    // enable dropped mid-window while a sample is pending
    ready = 1'b0;
    start_run(1, 0);
    ticks(6);
    enable = 1'b0;
    tick();
    chk("drop_valid", valid, 0);
    chk("drop_mclk", mic_clk, 0);
    ready = 1'b1;
    start_run(1, 1);
    stop_run();

    // one-clock reset pulse while valid and overrun are high
    ready = 1'b0;
    start_run(1, 0);
    ticks(16);
    chk("pre_rst_ovr", overrun, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("prst_mclk", mic_clk, 0);
    chk("prst_l", l, 0);
    chk("prst_r", r, 0);
    chk("prst_valid", valid, 0);
    chk("prst_ovr", overrun, 0);
    ready = 1'b1;
    start_run(1, 1);
    stop_run();

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
